operand_stack_cache: RTL
========================

Name: operand_stack_cache

Overview:
Parametrised next-generation operand stack for the pamPy stack machine, replacing the fixed-width stack/TOS register pair. The top two entries (TOS, NOS) are held in registers; deeper entries spill to a synchronous-read RAM. It accepts one stack op per valid/ready handshake and stalls for one or two refill cycles when RAM data must be pulled up. It feeds the ULA (top_out, next_out) and control unit (count, flags), and writes back ULA results via REPLACE2.

Parameters:
DATA_WIDTH, 8, width of one stack entry
DEPTH, 16, total capacity in entries including TOS/NOS; power of two, at least 4
CNT_WIDTH, $clog2(DEPTH)+1, derived localparam; count width, not overridable

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
op_valid  in  1  op request
op_ready  out  1  high when an op can be accepted (FSM in IDLE and reset low)
op_code  in  3  0 NOP, 1 PUSH, 2 POP, 3 REPLACE2, 4 DUP, 5 SWAP, 6 OVER, 7 DROP2
push_data  in  DATA_WIDTH  operand for PUSH and REPLACE2
top_out  out  DATA_WIDTH  TOS register; 0 when count<1
next_out  out  DATA_WIDTH  NOS register; 0 when count<2
count_out  out  CNT_WIDTH  number of valid entries, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
err_overflow  out  1  sticky, op rejected for lack of space
err_underflow  out  1  sticky, op rejected for lack of operands
err_clear  in  1  clears both sticky flags

Behaviour:
- Reset: count 0, TOS/NOS 0, FSM IDLE, empty 1, full 0, both error flags 0. op_ready is 0 while reset is high and 1 on the first cycle after. RAM contents are not cleared.
- Accept: an op is accepted on a clock edge when op_valid and op_ready are both high. NOP is accepted with no effect.
- Layout: RAM address k (k = 0..count-3) holds entry k from the bottom. The RAM has DEPTH-2 entries, one write port and one sync read port with 1-cycle latency.
- Validity requirements (count before the op):
  - PUSH, DUP: count<DEPTH.
  - OVER: count>=2 and count<DEPTH.
  - POP: count>=1.
  - REPLACE2, SWAP, DROP2: count>=2.
- Failed check: the op is still accepted. No change to data or count. Set err_underflow if the operand check failed, otherwise err_overflow. For OVER with both failing, underflow wins.
- Push-type ops (PUSH, DUP, OVER): if count>=2, write NOS to RAM[count-2]. Then NOS<=TOS, TOS<=new value (push_data, TOS, or NOS respectively), count+1. op_ready stays high; no stall.
- SWAP: exchange TOS and NOS in one cycle, no stall.
- POP: TOS<=NOS, count-1.
  - If count>=3: issue a read of RAM[count-3] and enter REFILL_NOS.
  - Otherwise: NOS<=0, stay IDLE.
- REPLACE2: TOS<=push_data, count-1. NOS refills exactly as for POP.
- DROP2: count-2.
  - count>=3: read RAM[count-3] and go to REFILL_TOS.
  - count==2: TOS<=0, NOS<=0, stay IDLE.
- FSM states and transitions:
  - IDLE: accepts ops.
  - REFILL_TOS: load TOS from RAM. If the new count>=2, read RAM[newcount-2] and go to REFILL_NOS; otherwise NOS<=0 and go to IDLE.
  - REFILL_NOS: load NOS from RAM, go to IDLE.
  - op_ready=0 in both REFILL states.
- Latency: POP/REPLACE2 with a refill stall 1 cycle; DROP2 stalls up to 2 cycles. count_out, empty and full update on the accept edge. top_out/next_out are final when op_ready returns high.
- Flags: set and err_clear in the same cycle means set wins. Flags persist through stalls and are cleared only by reset or err_clear.
- Reset mid-refill: abort the refill, apply reset values, discard the pending RAM read.
- Wrap: count never wraps; overflow and underflow are always rejected, never wrapped.

Decomposition:
- Package pampy_stack_pkg holds:
  - the op_code constants/enum;
  - the FSM state encoding (IDLE, REFILL_TOS, REFILL_NOS);
  - a function computing CNT_WIDTH.
- Sub-module stack_ram (DATA_WIDTH, DEPTH-2 entries, sync read, single write) is natural and lets it map to block RAM.

Test Plan:
- Reset, then PUSH 0x11, 0x22, 0x33, 0x44 (DEPTH=16) -> count 4, top 0x44, next 0x33, no stall, flags 0.
- From [11,22,33,44]: POP -> op_ready low exactly 1 cycle; then top 0x33, next 0x22, count 3.
- From [11,22,33,44]: DROP2 -> op_ready low 2 cycles; then top 0x22, next 0x11, count 2. Repeat DROP2 -> count 0, top 0, next 0, no stall.
- From [05,07]: REPLACE2 push_data 0x0C -> count 1, top 0x0C, next 0, no stall. Then SWAP -> err_underflow=1, state unchanged.
- Fill to 16 entries: PUSH -> err_overflow=1, full=1, count 16, top unchanged. Pulse err_clear together with another overflowing PUSH -> flag stays 1. err_clear alone -> flag clears to 0.
- Hold op_valid high across a POP refill, then assert reset during REFILL_NOS -> next cycle count 0, op_ready 1, outputs 0. Subsequent PUSH 0xAA -> top 0xAA, count 1.

Source files
------------

// File: rtl/pampy_stack_pkg.sv
// Shared types for the pamPy operand stack.
// Op codes, refill FSM states and derived widths.
package pampy_stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_PUSH     = 3'd1,
    OP_POP      = 3'd2,
    OP_REPLACE2 = 3'd3,
    OP_DUP      = 3'd4,
    OP_SWAP     = 3'd5,
    OP_OVER     = 3'd6,
    OP_DROP2    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REFILL_TOS = 2'd1,
    ST_REFILL_NOS = 2'd2
  } state_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Spill store for stack entries below NOS.
// One write port, one synchronous read port.
module stack_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ENTRIES    = 14,
  localparam int AW        = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/operand_stack_cache.sv
// Operand stack with TOS/NOS in registers and deeper entries in RAM.
// Pops that expose RAM data stall while the registers refill.
module operand_stack_cache
  import pampy_stack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int CNT_WIDTH = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [2:0]            op_code,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] top_out,
  output logic [DATA_WIDTH-1:0] next_out,
  output logic [CNT_WIDTH-1:0]  count_out,
  output logic                  empty,
  output logic                  full,
  output logic                  err_overflow,
  output logic                  err_underflow,
  input  logic                  err_clear
);

  localparam int ENTRIES = DEPTH - 2;
  localparam int AW      = $clog2(ENTRIES);

  localparam logic [CNT_WIDTH-1:0] C0   = '0;
  localparam logic [CNT_WIDTH-1:0] C1   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C2   = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] C3   = CNT_WIDTH'(3);
  localparam logic [CNT_WIDTH-1:0] CMAX = CNT_WIDTH'(DEPTH);

  state_e                state;
  logic [DATA_WIDTH-1:0] tos, nos;
  logic [CNT_WIDTH-1:0]  count;

  op_e                   op;
  logic                  accept;
  logic                  is_push, is_pull;
  logic                  under, over, op_ok;
  logic [DATA_WIDTH-1:0] push_val;
  logic [AW-1:0]         cnt_lo;

  logic                  ram_we, ram_re;
  logic [AW-1:0]         ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign op       = op_e'(op_code);
  assign op_ready = (state == ST_IDLE) && !reset;
  assign accept   = op_valid && op_ready;

  assign is_push = op inside {OP_PUSH, OP_DUP, OP_OVER};
  assign is_pull = op inside {OP_POP, OP_REPLACE2, OP_DROP2};

  assign under = ((op == OP_POP) && (count < C1)) ||
                 ((op inside {OP_REPLACE2, OP_SWAP, OP_OVER, OP_DROP2})
                  && (count < C2));
  assign over  = is_push && (count == CMAX);
  assign op_ok = !under && !over;

  assign push_val = (op == OP_DUP)  ? tos :
                    (op == OP_OVER) ? nos : push_data;

  // Low bits suffice: every RAM address used is below 2**AW.
  assign cnt_lo = count[AW-1:0];

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = cnt_lo - AW'(2);
    ram_raddr = cnt_lo - AW'(3);
    if (state == ST_REFILL_TOS) begin
      ram_re    = count >= C2;
      ram_raddr = cnt_lo - AW'(2);
    end else if (accept && op_ok) begin
      unique case (1'b1)
        is_push: ram_we = count >= C2;
        is_pull: ram_re = count >= C3;
        default: ;
      endcase
    end
  end

  stack_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ENTRIES    (ENTRIES)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (nos),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      tos           <= '0;
      nos           <= '0;
      count         <= C0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      err_underflow <= (accept && under) ||
                       (err_underflow && !err_clear);
      err_overflow  <= (accept && over && !under) ||
                       (err_overflow && !err_clear);
      unique case (state)
        ST_IDLE: begin
          if (accept && op_ok) begin
            unique case (op)
              OP_NOP: ;
              OP_PUSH, OP_DUP, OP_OVER: begin
                nos   <= tos;
                tos   <= push_val;
                count <= count + C1;
              end
              OP_SWAP: begin
                tos <= nos;
                nos <= tos;
              end
              OP_POP, OP_REPLACE2: begin
                tos   <= (op == OP_POP) ? nos : push_data;
                count <= count - C1;
                if (count >= C3) state <= ST_REFILL_NOS;
                else             nos   <= '0;
              end
              OP_DROP2: begin
                count <= count - C2;
                if (count >= C3) begin
                  state <= ST_REFILL_TOS;
                end else begin
                  tos <= '0;
                  nos <= '0;
                end
              end
            endcase
          end
        end
        ST_REFILL_TOS: begin
          tos <= ram_rdata;
          if (count >= C2) begin
            state <= ST_REFILL_NOS;
          end else begin
            nos   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_REFILL_NOS: begin
          nos   <= ram_rdata;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign top_out   = tos;
  assign next_out  = nos;
  assign count_out = count;
  assign empty     = count == C0;
  assign full      = count == CMAX;

endmodule
